// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the FIFO family: default geometry and read-mode type.
package sync_fifo_param_pkg;

    localparam int FIFO_DATASIZE = 8;
    localparam int FIFO_ADDRSIZE = 9;
    localparam int FIFO_DEPTH    = 1 << FIFO_ADDRSIZE;

    // Pointers carry one extra wrap bit above the memory index.
    function automatic int ptr_size(input int addrsize);
        return addrsize + 1;
    endfunction

    localparam int FIFO_PTRSIZE = ptr_size(FIFO_ADDRSIZE);

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

endpackage

// File: rtl/sync_fifo_param_fifomem.sv
// DEPTH x DATASIZE storage: synchronous write port, combinational read port.
module sync_fifomem
    import sync_fifo_param_pkg::*;
#(
    parameter int DATASIZE = FIFO_DATASIZE,
    parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
    input  logic                clk,
    input  logic                i_wen,
    input  logic [ADDRSIZE-1:0] i_waddr,
    input  logic [DATASIZE-1:0] i_wdata,
    input  logic [ADDRSIZE-1:0] i_raddr,
    output logic [DATASIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wen) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard / first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, fill level and sticky error flags.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATASIZE = FIFO_DATASIZE,
    parameter int ADDRSIZE = FIFO_ADDRSIZE,
    parameter int FWFT     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    input  logic [ADDRSIZE:0]   afull_lvl,
    input  logic [ADDRSIZE:0]   aempty_lvl,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   level,
    input  logic                err_clr,
    output logic                overflow,
    output logic                underflow
);

    localparam int       PTR   = ptr_size(ADDRSIZE);
    localparam int       DEPTH = 1 << ADDRSIZE;
    localparam rd_mode_e MODE  = (FWFT != 0) ? RD_FWFT : RD_STD;
    localparam logic [PTR-1:0] DEPTH_L = PTR'(DEPTH);

    logic [PTR-1:0]      r_wptr, r_rptr;
    logic                r_overflow, r_underflow;
    logic [PTR-1:0]      w_level;
    logic                w_full, w_empty, w_wacc, w_racc;
    logic [DATASIZE-1:0] w_mem_rdata;

    // Status decodes straight from the registered pointers; modulo subtraction
    // handles the wrap bit.
    assign w_level = r_wptr - r_rptr;
    assign w_full  = (w_level == DEPTH_L);
    assign w_empty = (w_level == '0);
    assign w_wacc  = winc & ~w_full;
    assign w_racc  = rinc & ~w_empty;

    // Pointer advance on accepted requests; no pass-through when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wacc) r_wptr <= r_wptr + 1'b1;
            if (w_racc) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Sticky errors; a fresh event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~err_clr) | (winc & w_full);
            r_underflow <= (r_underflow & ~err_clr) | (rinc & w_empty);
        end
    end

    sync_fifomem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk     (clk),
        .i_wen   (w_wacc),
        .i_waddr (r_wptr[ADDRSIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ADDRSIZE-1:0]),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (MODE == RD_STD) begin : g_std
            logic [DATASIZE-1:0] r_rdata;
            logic                r_rvalid;

            // Output register: capture the head on a pop, hold otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_racc;
                    if (w_racc) r_rdata <= w_mem_rdata;
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end else begin : g_fwft
            // Head shown directly; forced to zero while empty so reset and
            // idle states never expose stale memory.
            assign rdata  = w_empty ? '0 : w_mem_rdata;
            assign rvalid = ~w_empty;
        end
    endgenerate

    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign level         = w_level;
    assign walmost_full  = (w_level >= afull_lvl);
    assign ralmost_empty = (w_level <= aempty_lvl);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the synchronous successor of the team's Cummings-style asynchronous FIFO and reuses the same width/depth definitions package. Adds a selectable read mode (standard or first-word-fall-through), programmable almost-full and almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. Used as a local buffer on the write-burst / read-drain path, where producer and consumer share one clock.

Parameters:
DATASIZE, 8, data word width in bits
ADDRSIZE, 9, address width; DEPTH = 2**ADDRSIZE (512 by default)
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
winc  in  1  write request
wdata  in  DATASIZE  write data
rinc  in  1  read request (in FWFT mode: pop of the current head)
rdata  out  DATASIZE  read data
rvalid  out  1  rdata holds a newly popped word (standard mode); equals !rempty in FWFT mode
wfull  out  1  FIFO holds DEPTH words
rempty  out  1  FIFO holds 0 words
afull_lvl  in  ADDRSIZE+1  almost-full threshold
aempty_lvl  in  ADDRSIZE+1  almost-empty threshold
walmost_full  out  1  level >= afull_lvl
ralmost_empty  out  1  level <= aempty_lvl
level  out  ADDRSIZE+1  current word count, range 0..DEPTH
err_clr  in  1  synchronous clear of both sticky error flags
overflow  out  1  sticky flag: a write was dropped because the FIFO was full
underflow  out  1  sticky flag: a read was rejected because the FIFO was empty

Behaviour:
- One clock domain. rst_n is asynchronous and active-low; it is asserted asynchronously and released synchronously by the instantiating logic.
- Pointers: wptr and rptr, each ADDRSIZE+1 bits binary. The MSB is the wrap bit. level = wptr - rptr, modulo 2**(ADDRSIZE+1).
- wfull = (level == DEPTH); rempty = (level == 0). Both are decoded from registered pointers, so they update one cycle after the causing event.
- Write accepted = winc & !wfull. An accepted write stores wdata at mem[wptr[ADDRSIZE-1:0]] and increments wptr.
- Write while wfull: the write is dropped and overflow is set. This holds even if rinc is accepted in the same cycle; there is no pass-through when full.
- Read accepted = rinc & !rempty. An accepted read increments rptr.
- Read while rempty: the read is ignored and underflow is set. This holds even if winc is accepted in the same cycle.
- Simultaneous accepted write and read: level is unchanged and both pointers advance.
- Wrap-around: the pointer index bits roll over from DEPTH-1 to 0; the MSB toggles.
- Standard mode (FWFT=0):
  - rdata <= mem[rptr] on an accepted read; rvalid = 1 for exactly the following cycle.
  - rdata holds its value otherwise.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr] combinationally and is valid whenever !rempty.
  - rvalid = !rempty.
  - A write into an empty FIFO becomes visible (rempty falls) in the cycle after the write.
- Thresholds: walmost_full = (level >= afull_lvl); ralmost_empty = (level <= aempty_lvl). Both are unsigned compares and are combinational from level and the ports.
- Sticky flags: err_clr clears both overflow and underflow. A new error event in the same cycle as err_clr wins, so the flag is set.
- Reset values: wptr = 0, rptr = 0, level = 0, rempty = 1, wfull = 0, rdata = 0, rvalid = 0, overflow = 0, underflow = 0. ralmost_empty and walmost_full follow from level.
- Memory contents are not reset.
- Reset mid-operation returns every output to its reset value immediately. Data held in the FIFO is lost.

Decomposition:
- Shared package (definition): DATASIZE, ADDRSIZE, DEPTH, the POINTERSIZE = ADDRSIZE+1 constant, and a typedef enum {STD, FWFT} for the read mode.
- One sub-module: sync_fifomem, a DEPTH x DATASIZE memory with a synchronous write port and a combinational read port. Standard mode adds the output register in the parent.

Test Plan:
1. Reset with ADDRSIZE=4: check rempty=1, wfull=0, level=0, rvalid=0, overflow=0, underflow=0. Write 0x00..0x0F, then read 16 -> rdata 0x00..0x0F in order, one cycle after each rinc, and rempty=1 at the end.
2. Fill 16 words, then winc with 0xAA -> wfull=1, level stays 16, overflow=1. Drain -> 0xAA never appears. Pulse err_clr -> overflow=0.
3. On an empty FIFO, rinc & winc (0x55) in the same cycle -> underflow=1, level=1. The next read returns 0x55.
4. On a full FIFO, winc & rinc in the same cycle -> write dropped, level=15, overflow=1.
5. Set afull_lvl=12 and aempty_lvl=3, then write 12 words -> walmost_full rises on the 12th count and ralmost_empty falls at level=4. Run 40 writes/reads interleaved across the pointer wrap with a scoreboard -> no mismatches.
6. FWFT=1: write 0x3C -> the next cycle shows rempty=0, rdata=0x3C, rvalid=1. Assert rst_n=0 mid-burst -> all outputs return to reset values asynchronously.
